reset_sequencer: RTL

RESET_SEQUENCER -- requirements
Module: reset_sequencer

---
 rtl/reset_sequencer_pkg.sv | 18 +
 rtl/reset_debounce.sv | 40 ++++
 rtl/reset_sequencer.sv | 139 +++++++++++++
 3 files changed

// File: rtl/reset_sequencer_pkg.sv
// Shared definitions for the 68k reset sequencer: sequence states,
// reset-cause encodings and the width of the shared timing counter.
package reset_sequencer_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ASSERT    = 2'd1,
    HALT_TAIL = 2'd2,
    COOLDOWN  = 2'd3
  } seq_state_t;

  localparam logic [1:0] CAUSE_POR = 2'b00;
  localparam logic [1:0] CAUSE_WD  = 2'b01;
  localparam logic [1:0] CAUSE_BTN = 2'b10;

endpackage

// File: rtl/reset_debounce.sv
// Front-panel button conditioner: two-flop synchroniser followed by a
// consecutive-low counter. Emits one single-cycle pulse when the
// synchronised button has been low for DEBOUNCE cycles, and re-arms only
// once the synchronised level returns high.
module reset_debounce
  import reset_sequencer_pkg::*;
#(
  parameter int DEBOUNCE = 4
) (
  input  logic WDCLK,
  input  logic nRST,
  input  logic button_n,
  output logic trig
);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] low_cnt;

  // Synchronise, count consecutive lows (saturating at DEBOUNCE) and
  // pulse on the cycle the count reaches DEBOUNCE.
  always_ff @(posedge WDCLK) begin
    if (!nRST) begin
      sync_q  <= 2'b11;
      low_cnt <= '0;
      trig    <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], button_n};
      trig   <= 1'b0;
      if (sync_q[1]) begin
        low_cnt <= '0;
      end else if (low_cnt != CNT_W'(DEBOUNCE)) begin
        low_cnt <= low_cnt + 1'b1;
        if (low_cnt == CNT_W'(DEBOUNCE - 1)) begin
          trig <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// 68k reset sequencer. A power-on, watchdog or debounced button trigger
// runs nRESET low for RESET_LEN cycles, keeps nHALT low HALT_EXTRA cycles
// longer, pulses WD_REARM on the first cooldown cycle, and then ignores
// watchdog edges for COOLDOWN_LEN cycles. One down-counter times all
// three timed states. Outputs are registered from the next-state decode,
// so they change on the same edge as the state.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int RESET_LEN    = 16,
  parameter int HALT_EXTRA   = 2,
  parameter int COOLDOWN_LEN = 32,
  parameter int DEBOUNCE     = 4
) (
  input  logic       WDCLK,
  input  logic       nRST,
  input  logic       nWDTRIG,
  input  logic       nBUTTON,
  output logic       nRESET,
  output logic       nHALT,
  output logic [1:0] RST_CAUSE,
  output logic [7:0] WD_COUNT,
  output logic       WD_REARM,
  output logic [1:0] dbg_state
);

  seq_state_t       state, next_state;
  logic [CNT_W-1:0] cnt, next_cnt;
  logic             next_nreset, next_nhalt, next_rearm;
  logic             wd_prev;
  logic             btn_trig;
  logic             wd_edge;
  logic             accept_btn, accept_wd, accept;

  reset_debounce #(
    .DEBOUNCE(DEBOUNCE)
  ) u_debounce (
    .WDCLK   (WDCLK),
    .nRST    (nRST),
    .button_n(nBUTTON),
    .trig    (btn_trig)
  );

  // Falling edge only: a held-low nWDTRIG never re-triggers. The button
  // wins a tie, and is also honoured during cooldown; watchdog edges are
  // only honoured in IDLE.
  assign wd_edge    = wd_prev & ~nWDTRIG;
  assign accept_btn = btn_trig && (state == IDLE || state == COOLDOWN);
  assign accept_wd  = wd_edge && (state == IDLE) && !btn_trig;
  assign accept     = accept_btn | accept_wd;
  assign dbg_state  = state;

  // State register, shared counter and registered reset outputs.
  always_ff @(posedge WDCLK) begin
    if (!nRST) begin
      state    <= ASSERT;
      cnt      <= CNT_W'(RESET_LEN);
      nRESET   <= 1'b0;
      nHALT    <= 1'b0;
      WD_REARM <= 1'b0;
    end else begin
      state    <= next_state;
      cnt      <= next_cnt;
      nRESET   <= next_nreset;
      nHALT    <= next_nhalt;
      WD_REARM <= next_rearm;
    end
  end

  // Next state and counter: each timed state leaves when the counter
  // reads 1, loading the length of the following state.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    unique case (state)
      IDLE: begin
        if (accept) begin
          next_state = ASSERT;
          next_cnt   = CNT_W'(RESET_LEN);
        end
      end
      ASSERT: begin
        if (cnt == CNT_W'(1)) begin
          next_state = HALT_TAIL;
          next_cnt   = CNT_W'(HALT_EXTRA);
        end else begin
          next_cnt = cnt - 1'b1;
        end
      end
      HALT_TAIL: begin
        if (cnt == CNT_W'(1)) begin
          next_state = COOLDOWN;
          next_cnt   = CNT_W'(COOLDOWN_LEN);
        end else begin
          next_cnt = cnt - 1'b1;
        end
      end
      COOLDOWN: begin
        if (accept) begin
          next_state = ASSERT;
          next_cnt   = CNT_W'(RESET_LEN);
        end else if (cnt == CNT_W'(1)) begin
          next_state = IDLE;
          next_cnt   = '0;
        end else begin
          next_cnt = cnt - 1'b1;
        end
      end
    endcase
  end

  // Output decode from the next state; nHALT is only released in states
  // where nRESET is already high.
  always_comb begin
    next_nreset = (next_state != ASSERT);
    next_nhalt  = (next_state == IDLE) || (next_state == COOLDOWN);
    next_rearm  = (state == HALT_TAIL) && (next_state == COOLDOWN);
  end

  // Cause and saturating watchdog tally, updated on the accepting edge.
  always_ff @(posedge WDCLK) begin
    if (!nRST) begin
      wd_prev   <= 1'b1;
      RST_CAUSE <= CAUSE_POR;
      WD_COUNT  <= '0;
    end else begin
      wd_prev <= nWDTRIG;
      if (accept_btn) begin
        RST_CAUSE <= CAUSE_BTN;
      end else if (accept_wd) begin
        RST_CAUSE <= CAUSE_WD;
        if (WD_COUNT != 8'hFF) begin
          WD_COUNT <= WD_COUNT + 1'b1;
        end
      end
    end
  end

endmodule
